// File: rtl/branch_pkg.sv
// Shared types and constants for the branch/jump resolution sequencer and its BRU.
package branch_pkg;

  typedef enum logic [1:0] {
    OP_BR   = 2'd0,
    OP_JAL  = 2'd1,
    OP_JALR = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REDIR  = 2'd2,
    ST_RETIRE = 2'd3
  } state_e;

  localparam logic [2:0] F_BEQ  = 3'b000;
  localparam logic [2:0] F_BNE  = 3'b001;
  localparam logic [2:0] F_BLT  = 3'b100;
  localparam logic [2:0] F_BGE  = 3'b101;
  localparam logic [2:0] F_BLTU = 3'b110;
  localparam logic [2:0] F_BGEU = 3'b111;

  // Encoding 3 is reserved and behaves as a conditional branch.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_op = OP_JAL;
      2'd2:    decode_op = OP_JALR;
      default: decode_op = OP_BR;
    endcase
  endfunction

endpackage

// File: rtl/branch_ctrl_bru.sv
// Branch resolution unit: evaluates a funct3 branch condition on two operands.
module branch_ctrl_bru
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [2:0]      funct,
  output logic            jump_en
);

  always_comb begin
    jump_en = 1'b0;
    case (funct)
      F_BEQ:   jump_en = (src1 == src2);
      F_BNE:   jump_en = (src1 != src2);
      F_BLT:   jump_en = ($signed(src1) <  $signed(src2));
      F_BGE:   jump_en = ($signed(src1) >= $signed(src2));
      F_BLTU:  jump_en = (src1 <  src2);
      F_BGEU:  jump_en = (src1 >= src2);
      default: jump_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump sequencer: waits for operands, resolves the real next PC, redirects
// the IFU on a mispredict, then retires the link value and keeps perf counters.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready are
// both high; valid never drops and its payload never changes before that edge,
// except when flush aborts the operation.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [2:0]       in_funct,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  input  logic             src1_ok,
  input  logic             src2_ok,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_wen,
  output logic [XLEN-1:0]  out_link,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output state_e           dbg_state
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [2:0]        funct_q;
  logic [XLEN-1:0]   pc_q, imm_q, pred_target_q;
  logic              pred_taken_q;
  logic [XLEN-1:0]   redirect_pc_q, out_link_q;
  logic              out_wen_q;
  logic [CNT_W-1:0]  br_cnt_q, miss_cnt_q;

  logic              accept, operands_ok, resolve;
  logic              jump_en, taken, mispredict;
  logic [XLEN-1:0]   target, next_pc, link, jalr_sum;

  assign in_ready    = (state_q == ST_IDLE) && !flush;
  assign accept      = in_valid && in_ready;
  // JAL carries no register operands, so it resolves on its first WAIT cycle.
  assign operands_ok = (op_q == OP_JAL) || (src1_ok && (src2_ok || (op_q != OP_BR)));
  assign resolve     = (state_q == ST_WAIT) && operands_ok && !flush;

  branch_ctrl_bru #(.XLEN(XLEN)) u_bru (
    .src1    (src1),
    .src2    (src2),
    .funct   (funct_q),
    .jump_en (jump_en)
  );

  assign jalr_sum = src1 + imm_q;
  assign link     = pc_q + XLEN'(4);

  always_comb begin
    taken  = 1'b1;
    target = pc_q + imm_q;
    case (op_q)
      OP_BR:   taken  = jump_en;
      OP_JALR: target = {jalr_sum[XLEN-1:1], 1'b0};
      default: ;
    endcase
    next_pc    = taken ? target : link;
    mispredict = (taken != pred_taken_q) || (taken && (target != pred_target_q));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept)         state_d = ST_WAIT;
      ST_WAIT:   if (operands_ok)    state_d = mispredict ? ST_REDIR : ST_RETIRE;
      ST_REDIR:  if (redirect_ready) state_d = ST_RETIRE;
      ST_RETIRE: if (out_ready)      state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_BR;
      funct_q       <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      redirect_pc_q <= '0;
      out_link_q    <= '0;
      out_wen_q     <= 1'b0;
      br_cnt_q      <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q          <= decode_op(in_op);
        funct_q       <= in_funct;
        pc_q          <= in_pc;
        imm_q         <= in_imm;
        pred_taken_q  <= in_pred_taken;
        pred_target_q <= in_pred_target;
      end
      if (resolve) begin
        redirect_pc_q <= next_pc;
        out_link_q    <= link;
        out_wen_q     <= (op_q != OP_BR);
        if (op_q == OP_BR) br_cnt_q   <= br_cnt_q + CNT_W'(1);
        if (mispredict)    miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign redirect_valid = (state_q == ST_REDIR);
  assign out_valid      = (state_q == ST_RETIRE);
  assign redirect_pc    = redirect_pc_q;
  assign out_link       = out_link_q;
  assign out_wen        = out_wen_q;
  assign br_cnt         = br_cnt_q;
  assign miss_cnt       = miss_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: directed cases, flush cases, counter wrap and
// randomized traffic checked against a behavioural next-PC/mispredict model.
module tb_branch_ctrl;
  import branch_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = '0;
  logic [2:0]       in_funct = '0;
  logic [XLEN-1:0]  in_pc = '0, in_imm = '0, in_pred_target = '0;
  logic             in_pred_taken = 1'b0;
  logic             src1_ok = 1'b0, src2_ok = 1'b0;
  logic [XLEN-1:0]  src1 = '0, src2 = '0;
  logic             redirect_valid;
  logic             redirect_ready = 1'b0;
  logic [XLEN-1:0]  redirect_pc;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_wen;
  logic [XLEN-1:0]  out_link;
  logic [CNT_W-1:0] br_cnt, miss_cnt;
  state_e           dbg_state;

  branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_funct(in_funct),
    .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .src1_ok(src1_ok), .src2_ok(src2_ok),
    .src1(src1), .src2(src2), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_wen(out_wen),
    .out_link(out_link), .br_cnt(br_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic             wen;
    logic [XLEN-1:0]  link;
    logic [CNT_W-1:0] br;
    logic [CNT_W-1:0] miss;
  } ret_t;

  logic [XLEN-1:0] exp_q[$];
  ret_t            ret_q[$];

  int n_cmp = 0, n_err = 0;
  int ready_mode = 1;   // 0 random, 1 always ready, 2 redirect stalled
  int acc_cyc = 0, last_ret_cyc = 0;
  int m_br = 0, m_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: architectural branch rules, no knowledge of the FSM.
  function automatic void model(input logic [1:0] op, input logic [2:0] f,
                                input logic [XLEN-1:0] pc, imm, s1, s2,
                                input logic pt, input logic [XLEN-1:0] ptgt,
                                output logic mis, output logic [XLEN-1:0] npc);
    logic taken;
    logic [XLEN-1:0] tgt;
    tgt = pc + imm;
    taken = 1'b1;
    if (op == 2'd2) tgt = (s1 + imm) & ~32'd1;
    else if (op != 2'd1) begin
      case (f)
        3'b000:  taken = (s1 == s2);
        3'b001:  taken = (s1 != s2);
        3'b100:  taken = ($signed(s1) < $signed(s2));
        3'b101:  taken = ($signed(s1) >= $signed(s2));
        3'b110:  taken = (s1 < s2);
        3'b111:  taken = (s1 >= s2);
        default: taken = 1'b0;
      endcase
    end
    npc = taken ? tgt : pc + 32'd4;
    mis = (taken != pt) || (taken && (tgt != ptgt));
  endfunction

  // ---------------- driver tasks ----------------
  always @(posedge clock) begin
    #2;
    case (ready_mode)
      0: begin
        redirect_ready = ($urandom_range(0, 2) != 0);
        out_ready      = ($urandom_range(0, 2) != 0);
      end
      1: begin redirect_ready = 1'b1; out_ready = 1'b1; end
      default: begin redirect_ready = 1'b0; out_ready = 1'b1; end
    endcase
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] f,
                       input logic [XLEN-1:0] pc, imm, s1, s2,
                       input logic pt, input logic [XLEN-1:0] ptgt,
                       input int d1, input int d2, input bit flush_res, input bit push);
    logic mis;
    logic [XLEN-1:0] npc;
    int kres;
    bit acc;
    ret_t r;
    model(op, f, pc, imm, s1, s2, pt, ptgt, mis, npc);
    kres = (op == 2'd1) ? 0 : (op == 2'd2) ? d1 : ((d1 > d2) ? d1 : d2);
    acc = 1'b0;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_op = op; in_funct = f; in_pc = pc; in_imm = imm;
      in_pred_taken = pt; in_pred_target = ptgt; src1 = s1; src2 = s2;
      src1_ok = 1'b0; src2_ok = 1'b0;
      #1;
      if (in_ready) begin acc = 1'b1; acc_cyc = cyc; end
    end
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (!flush_res) begin
      m_br   += ((op == 2'd0) || (op == 2'd3)) ? 1 : 0;
      m_miss += mis ? 1 : 0;
      if (push) begin
        if (mis) exp_q.push_back(npc);
        r.wen  = (op == 2'd1) || (op == 2'd2);
        r.link = pc + 32'd4;
        r.br   = CNT_W'(m_br);
        r.miss = CNT_W'(m_miss);
        ret_q.push_back(r);
      end
    end
    for (int k = 0; k <= kres; k++) begin
      @(negedge clock);
      in_valid = 1'b0;
      src1_ok = (k >= d1);
      src2_ok = (k >= d2);
      if (k == kres && flush_res) flush = 1'b1;
    end
    @(negedge clock);
    src1_ok = 1'b0; src2_ok = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0 && ret_q.size() == 0 && in_ready) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic            prev_stall = 1'b0;
  logic [XLEN-1:0] prev_rpc = '0;

  always @(negedge clock) begin
    logic [XLEN-1:0] e;
    ret_t r;
    if (!reset_n) prev_stall = 1'b0;
    else begin
      if (redirect_valid) begin
        if (prev_stall) chk("redirect_pc_stable", redirect_pc, prev_rpc);
        if (redirect_ready) begin
          if (exp_q.size() == 0) chk("redirect_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("redirect_pc", redirect_pc, e);
          end
        end
      end
      prev_stall = redirect_valid && !redirect_ready;
      prev_rpc   = redirect_pc;
      if (out_valid && out_ready) begin
        last_ret_cyc = cyc;
        if (ret_q.size() == 0) chk("retire_unexpected", 1, 0);
        else begin
          r = ret_q.pop_front();
          chk("out_wen", out_wen, r.wen);
          chk("out_link", out_link, r.link);
          chk("br_cnt", br_cnt, r.br);
          chk("miss_cnt", miss_cnt, r.miss);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] op;
    logic [XLEN-1:0] pc, imm, s1, s2, tgt;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_wen", out_wen, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_out_link", out_link, 0);
    chk("rst_br_cnt", br_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;

    // BEQ taken but predicted not-taken: redirect to pc+imm
    issue(2'd0, F_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0, 0, 0, 1'b0, 1'b1);
    wait_idle();
    chk("lat_mispredict", last_ret_cyc - acc_cyc, 3);
    chk("beq_br_cnt", br_cnt, 1);
    chk("beq_miss_cnt", miss_cnt, 1);

    // BLT signed -1 < 1, correctly predicted
    issue(2'd0, F_BLT, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h240, 0, 0, 1'b0, 1'b1);
    wait_idle();
    chk("lat_nomiss", last_ret_cyc - acc_cyc, 2);
    chk("blt_miss_cnt", miss_cnt, 1);

    // BLTU same operands: not taken, falls through to pc+4
    issue(2'd0, F_BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h240, 0, 0, 1'b0, 1'b1);
    wait_idle();

    // JALR with rs1 late by 3 cycles; target LSB cleared
    issue(2'd2, 3'd0, 32'h300, 32'h4, 32'h1003, 32'h0, 1'b0, 32'h0, 3, 0, 1'b0, 1'b1);
    wait_idle();
    chk("lat_jalr_wait3", last_ret_cyc - acc_cyc, 6);

    // Redirect stalled 5 cycles, then flushed
    ready_mode = 2;
    issue(2'd0, F_BNE, 32'h400, 32'h10, 32'd1, 32'd2, 1'b0, 32'h0, 0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_redirect_valid", redirect_valid, 1);
      chk("stall_redirect_pc", redirect_pc, 32'h410);
      @(negedge clock);
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("flush_redirect_valid", redirect_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("flush_no_out_valid", out_valid, 0);
    end
    ready_mode = 1;

    // Flush in the resolve cycle: counters must not move
    issue(2'd1, 3'd0, 32'h500, 32'h80, 32'h0, 32'h0, 1'b0, 32'h0, 2, 2, 1'b1, 1'b0);
    #1;
    chk("rflush_in_ready", in_ready, 1);
    chk("rflush_redirect_valid", redirect_valid, 0);
    chk("rflush_br_cnt", br_cnt, CNT_W'(m_br));
    chk("rflush_miss_cnt", miss_cnt, CNT_W'(m_miss));

    // 2^CNT_W mispredicting JALs wrap miss_cnt back to its start value
    for (int i = 0; i < 16; i++)
      issue(2'd1, 3'd0, 32'h600 + 32'(i * 4), 32'h40, 32'h0, 32'h0, 1'b0, 32'h0,
            $urandom_range(0, 3), 0, 1'b0, 1'b1);
    wait_idle();
    chk("wrap_miss_cnt", miss_cnt, CNT_W'(m_miss));

    // Randomized traffic with random back-pressure
    ready_mode = 0;
    for (int n = 0; n < 80; n++) begin
      op  = 2'($urandom_range(0, 3));
      pc  = $urandom & ~32'd3;
      imm = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : $urandom;
      s1  = 32'($urandom_range(0, 3)) - 32'd2;
      s2  = ($urandom_range(0, 1) != 0) ? s1 : 32'($urandom_range(0, 3)) - 32'd1;
      tgt = (op == 2'd2) ? ((s1 + imm) & ~32'd1) : pc + imm;
      issue(op, 3'($urandom_range(0, 7)), pc, imm, s1, s2, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0) ? tgt : $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1);
    end
    wait_idle();
    chk("leftover_redirects", 32'(exp_q.size()), 0);
    chk("leftover_retires", 32'(ret_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
